// File: rtl/mem_arb_pkg.sv
// Shared types for the L1 memory-port arbiter: transaction and flush-aggregation states.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP
  } arb_state_t;

  typedef enum logic {
    FLUSH_IDLE,
    FLUSH_BUSY
  } flush_state_t;

endpackage

// File: rtl/l1_mem_arbiter_n_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo N_CLIENTS.
module rr_pick #(
  parameter int N_CLIENTS = 4,
  localparam int CW = $clog2(N_CLIENTS)
) (
  input  logic [N_CLIENTS-1:0] req,
  input  logic [CW-1:0]        last,
  output logic                 any,
  output logic [CW-1:0]        winner
);

  logic          found;
  logic [CW-1:0] idx;

  // NOTE: every output and temporary gets a default first so no path infers a latch.
  always_comb begin
    any    = |req;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N_CLIENTS; k++) begin
      idx = CW'((int'(last) + k) % N_CLIENTS);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l1_mem_arbiter_n.sv
// Shares one cache-line memory port among N L1 clients, one transaction in flight,
// and folds per-cache flush completions into a single flush-busy indication.
module l1_mem_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int ADDR_W    = 64,
  parameter int LINE_W    = 128,
  parameter int TAG_W     = 2,
  parameter int OP_W      = 5,
  parameter int TIMEOUT   = 1024,
  localparam int CW       = $clog2(N_CLIENTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CLIENTS-1:0]        cli_req_valid,
  input  logic [N_CLIENTS*ADDR_W-1:0] cli_req_addr,
  input  logic [N_CLIENTS*LINE_W-1:0] cli_req_store_data,
  input  logic [N_CLIENTS*TAG_W-1:0]  cli_req_tag,
  input  logic [N_CLIENTS*OP_W-1:0]   cli_req_opcode,
  output logic [N_CLIENTS-1:0]        cli_rsp_valid,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ack,
  output logic [ADDR_W-1:0]           mem_req_addr,
  output logic [LINE_W-1:0]           mem_req_store_data,
  output logic [TAG_W-1:0]            mem_req_tag,
  output logic [OP_W-1:0]             mem_req_opcode,
  output logic [CW-1:0]               mem_req_client,
  input  logic                        mem_rsp_valid,
  input  logic                        flush_req,
  input  logic [N_CLIENTS-1:0]        cli_flush_done,
  output logic                        flush_busy,
  output logic                        flush_complete,
  output logic                        rsp_err,
  output logic                        timeout
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;

  arb_state_t             state_q, state_d;
  flush_state_t           flush_q, flush_d;
  logic [N_CLIENTS-1:0]   pend_q, pend_d;
  logic [N_CLIENTS-1:0]   done_mask_q, done_mask_d;
  logic [CW-1:0]          gnt_q, gnt_d;
  logic [CW-1:0]          last_q, last_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   timeout_q, timeout_d;

  logic                   pick_any;
  logic [CW-1:0]          pick_idx;
  logic [N_CLIENTS-1:0]   gnt_onehot;
  logic [N_CLIENTS-1:0]   in_service;
  logic [N_CLIENTS-1:0]   done_all;
  logic                   rsp_fire;

  rr_pick #(.N_CLIENTS(N_CLIENTS)) u_rr_pick (
    .req    (pend_q | cli_req_valid),
    .last   (last_q),
    .any    (pick_any),
    .winner (pick_idx)
  );

  assign gnt_onehot = N_CLIENTS'(1) << gnt_q;
  assign in_service = (state_q != IDLE) ? gnt_onehot : '0;
  assign rsp_fire   = mem_rsp_valid &&
                      ((state_q == REQ && mem_req_ack) || state_q == WAIT_RSP);

  // A repeat pulse from the client already in service is a protocol error and is dropped.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q | (cli_req_valid & ~in_service);
    gnt_d     = gnt_q;
    last_d    = last_q;
    wd_d      = wd_q;
    rsp_err_d = rsp_err_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (mem_rsp_valid) rsp_err_d = 1'b1;
        if (pick_any) begin
          gnt_d            = pick_idx;
          last_d           = pick_idx;
          pend_d[pick_idx] = 1'b0;
          state_d          = REQ;
        end
      end
      REQ: begin
        if (mem_req_ack) begin
          state_d = mem_rsp_valid ? IDLE : WAIT_RSP;
          wd_d    = '0;
        end else if (mem_rsp_valid) begin
          rsp_err_d = 1'b1;
        end
      end
      WAIT_RSP: begin
        // Saturating watchdog; the flag is informational and never aborts the wait.
        if (wd_q != WD_W'(TIMEOUT)) wd_d = wd_q + 1'b1;
        if (wd_d == WD_W'(TIMEOUT)) timeout_d = 1'b1;
        if (mem_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign done_all = done_mask_q | cli_flush_done;

  always_comb begin
    flush_d     = flush_q;
    done_mask_d = done_mask_q;
    case (flush_q)
      FLUSH_IDLE: begin
        if (flush_req) begin
          flush_d     = FLUSH_BUSY;
          done_mask_d = '0;
        end
      end
      FLUSH_BUSY: begin
        if (&done_all) flush_d = FLUSH_IDLE;
        else           done_mask_d = done_all;
      end
      default: flush_d = FLUSH_IDLE;
    endcase
  end

  // NOTE: flops use non-blocking assignment so all of them sample pre-edge _d values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      flush_q     <= FLUSH_IDLE;
      pend_q      <= '0;
      done_mask_q <= '0;
      gnt_q       <= '0;
      last_q      <= CW'(N_CLIENTS - 1);
      wd_q        <= '0;
      rsp_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      pend_q      <= pend_d;
      done_mask_q <= done_mask_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      wd_q        <= wd_d;
      rsp_err_q   <= rsp_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign mem_req_valid      = (state_q == REQ);
  assign mem_req_client     = gnt_q;
  assign mem_req_addr       = cli_req_addr[int'(gnt_q)*ADDR_W +: ADDR_W];
  assign mem_req_store_data = cli_req_store_data[int'(gnt_q)*LINE_W +: LINE_W];
  assign mem_req_tag        = cli_req_tag[int'(gnt_q)*TAG_W +: TAG_W];
  assign mem_req_opcode     = cli_req_opcode[int'(gnt_q)*OP_W +: OP_W];
  assign cli_rsp_valid      = rsp_fire ? gnt_onehot : '0;
  assign flush_busy         = (flush_q == FLUSH_BUSY);
  assign flush_complete     = (flush_q == FLUSH_BUSY) && (&done_all);
  assign rsp_err            = rsp_err_q;
  assign timeout            = timeout_q;

endmodule

// File: tb/tb_l1_mem_arbiter_n.sv
// Scoreboard bench for l1_mem_arbiter_n: a transaction-level model predicts grants and
// responses into queues; a negedge monitor pops and compares whenever the DUT shows one.
module tb_l1_mem_arbiter_n;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int LW = 128;
  localparam int TW = 2;
  localparam int OW = 5;
  localparam int TO = 16;
  localparam int PW = AW + TW + OW + LW;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      cli_req_valid;
  logic [N*AW-1:0]   cli_req_addr;
  logic [N*LW-1:0]   cli_req_store_data;
  logic [N*TW-1:0]   cli_req_tag;
  logic [N*OW-1:0]   cli_req_opcode;
  logic [N-1:0]      cli_rsp_valid;
  logic              mem_req_valid;
  logic              mem_req_ack;
  logic [AW-1:0]     mem_req_addr;
  logic [LW-1:0]     mem_req_store_data;
  logic [TW-1:0]     mem_req_tag;
  logic [OW-1:0]     mem_req_opcode;
  logic [1:0]        mem_req_client;
  logic              mem_rsp_valid;
  logic              flush_req;
  logic [N-1:0]      cli_flush_done;
  logic              flush_busy;
  logic              flush_complete;
  logic              rsp_err;
  logic              timeout;

  always #5 clk = ~clk;

  l1_mem_arbiter_n #(
    .N_CLIENTS(N), .ADDR_W(AW), .LINE_W(LW), .TAG_W(TW), .OP_W(OW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cli_req_valid(cli_req_valid), .cli_req_addr(cli_req_addr),
    .cli_req_store_data(cli_req_store_data), .cli_req_tag(cli_req_tag),
    .cli_req_opcode(cli_req_opcode), .cli_rsp_valid(cli_rsp_valid),
    .mem_req_valid(mem_req_valid), .mem_req_ack(mem_req_ack),
    .mem_req_addr(mem_req_addr), .mem_req_store_data(mem_req_store_data),
    .mem_req_tag(mem_req_tag), .mem_req_opcode(mem_req_opcode),
    .mem_req_client(mem_req_client), .mem_rsp_valid(mem_rsp_valid),
    .flush_req(flush_req), .cli_flush_done(cli_flush_done),
    .flush_busy(flush_busy), .flush_complete(flush_complete),
    .rsp_err(rsp_err), .timeout(timeout)
  );

  typedef enum {PH_IDLE, PH_REQ, PH_WAIT} ph_t;
  typedef struct { int client; int cyc; logic [PW-1:0] pay; } grant_t;
  typedef struct { logic [N-1:0] hot; int cyc; } rsp_t;

  int       n_cmp = 0;
  int       n_fail = 0;
  int       cyc = 0;
  bit       mon_en = 1'b0;
  logic     exp_mem_valid = 1'b0;
  logic     prev_valid = 1'b0;
  grant_t   grant_q[$];
  rsp_t     rsp_q[$];
  int       seen[$];

  // Reference model state: who is waiting, who is served, where the pointer sits.
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_out = '0;
  int           m_last = N - 1;
  int           m_gnt = 0;
  int           m_wait = 0;
  ph_t          m_phase = PH_IDLE;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input string what);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  function automatic int rr_next(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (req[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic deliver();
    rsp_t r;
    r.hot = N'(1) << m_gnt;
    r.cyc = cyc;
    rsp_q.push_back(r);
    m_out[m_gnt] = 1'b0;
    m_phase = PH_IDLE;
  endtask

  // One clock of stimulus; the model predicts what the DUT must show for it.
  task automatic step(input logic [N-1:0] p, input logic ack, input logic rsp,
                      input logic frq, input logic [N-1:0] fd, input logic rst);
    int w;
    grant_t g;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (p[i]) begin
        cli_req_addr[i*AW +: AW]       = {$urandom, $urandom};
        cli_req_store_data[i*LW +: LW] = {$urandom, $urandom, $urandom, $urandom};
        cli_req_tag[i*TW +: TW]        = TW'($urandom);
        cli_req_opcode[i*OW +: OW]     = OW'($urandom);
        m_out[i] = 1'b1;
      end
    end
    reset = rst; cli_req_valid = p; mem_req_ack = ack; mem_rsp_valid = rsp;
    flush_req = frq; cli_flush_done = fd;
    exp_mem_valid = (m_phase == PH_REQ);
    if (rst) begin
      m_pend = '0; m_out = '0; m_last = N - 1; m_gnt = 0; m_phase = PH_IDLE;
      return;
    end
    case (m_phase)
      PH_IDLE: begin
        w = rr_next(m_pend | p, m_last);
        m_pend |= p;
        if (w >= 0) begin
          g.client = w;
          g.cyc    = cyc + 1;
          g.pay    = {cli_req_addr[w*AW +: AW], cli_req_tag[w*TW +: TW],
                      cli_req_opcode[w*OW +: OW], cli_req_store_data[w*LW +: LW]};
          grant_q.push_back(g);
          m_pend[w] = 1'b0; m_last = w; m_gnt = w; m_phase = PH_REQ;
        end
      end
      PH_REQ: begin
        m_pend |= p;
        if (ack) begin
          if (rsp) deliver();
          else begin m_phase = PH_WAIT; m_wait = 0; end
        end
      end
      default: begin
        m_pend |= p;
        if (rsp) deliver();
        else m_wait++;
      end
    endcase
  endtask

  task automatic idle();
    step('0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic auto_cycle(input logic [N-1:0] p);
    step(p, m_phase == PH_REQ, m_phase == PH_WAIT, 1'b0, '0, 1'b0);
  endtask

  task automatic rand_cycle();
    logic [N-1:0] p;
    logic a, r;
    p = '0; a = 1'b0; r = 1'b0;
    for (int i = 0; i < N; i++)
      if (!m_out[i] && $urandom_range(3) == 0) p[i] = 1'b1;
    if (m_phase == PH_REQ && $urandom_range(1) == 1) begin
      a = 1'b1;
      r = ($urandom_range(3) == 0);
    end else if (m_phase == PH_WAIT) begin
      r = (m_wait >= 7) || ($urandom_range(2) == 0);
    end
    step(p, a, r, 1'b0, '0, 1'b0);
  endtask

  // Monitor: pops an expectation each time the DUT presents a grant or a response.
  always @(negedge clk) begin
    if (mon_en) begin
      grant_t g;
      rsp_t   r;
      check("mem_req_valid", mem_req_valid, exp_mem_valid);
      if (mem_req_valid && !prev_valid) begin
        if (grant_q.size() == 0) flag("unexpected_grant", $sformatf("client %0d", mem_req_client));
        else begin
          g = grant_q.pop_front();
          check("grant_client", mem_req_client, g.client);
          check("grant_cycle", cyc, g.cyc);
          check("grant_payload", {mem_req_addr, mem_req_tag, mem_req_opcode, mem_req_store_data}, g.pay);
          seen.push_back(int'(mem_req_client));
        end
      end else if (grant_q.size() != 0 && grant_q[0].cyc < cyc) begin
        flag("missing_grant", $sformatf("client %0d never granted", grant_q[0].client));
        void'(grant_q.pop_front());
      end
      if (cli_rsp_valid != '0) begin
        if (rsp_q.size() == 0) flag("unexpected_rsp", $sformatf("strobe %b", cli_rsp_valid));
        else begin
          r = rsp_q.pop_front();
          check("rsp_strobe", cli_rsp_valid, r.hot);
          check("rsp_cycle", cyc, r.cyc);
        end
      end else if (rsp_q.size() != 0 && rsp_q[0].cyc <= cyc) begin
        flag("missing_rsp", $sformatf("strobe %b not seen", rsp_q[0].hot));
        void'(rsp_q.pop_front());
      end
      prev_valid = mem_req_valid;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
    check({tag, "_cli_rsp_valid"}, cli_rsp_valid, '0);
    check({tag, "_mem_req_client"}, mem_req_client, 2'd0);
    check({tag, "_flush_busy"}, flush_busy, 1'b0);
    check({tag, "_flush_complete"}, flush_complete, 1'b0);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    check({tag, "_timeout"}, timeout, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_order[5] = '{0, 2, 3, 0, 2};
    int guard;
    bit injected;
    reset = 1'b1; cli_req_valid = '0; mem_req_ack = 1'b0; mem_rsp_valid = 1'b0;
    flush_req = 1'b0; cli_flush_done = '0;
    cli_req_addr = '0; cli_req_store_data = '0; cli_req_tag = '0; cli_req_opcode = '0;
    repeat (3) step('0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    mon_en = 1'b1;
    idle();
    @(negedge clk) check_reset_values("reset");

    // Single client 1: grant next cycle, ack at t3, response at t5.
    step(4'b0010, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle();
    @(negedge clk) check("tp1_client", mem_req_client, 2'd1);
    idle();
    step('0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    idle();
    @(negedge clk) check("tp1_valid_after_ack", mem_req_valid, 1'b0);
    step('0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk) check("tp1_rsp", cli_rsp_valid, 4'b0010);
    idle();

    // Round-robin order after reset, with re-pulses while client 3 is served.
    step('0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle();
    seen.delete();
    injected = 1'b0;
    auto_cycle(4'b1101);
    for (int k = 0; k < 18; k++) begin
      if (!injected && m_phase != PH_IDLE && m_gnt == 3) begin
        auto_cycle(4'b0101);
        injected = 1'b1;
      end else auto_cycle('0);
    end
    check("tp2_grant_count", seen.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("tp2_order_%0d", i), (i < seen.size()) ? seen[i] : -1, exp_order[i]);

    // Ack and response together in REQ.
    step(4'b0001, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step('0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk) check("ackrsp_strobe", cli_rsp_valid, 4'b0001);
    idle();
    @(negedge clk) check("ackrsp_no_err", rsp_err, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) rand_cycle();
    guard = 0;
    while ((m_out != '0 || m_phase != PH_IDLE) && guard < 300) begin
      auto_cycle('0);
      guard++;
    end
    if (guard >= 300) flag("drain", "outstanding clients never drained");
    repeat (2) idle();
    @(negedge clk);
    check("rand_rsp_err", rsp_err, 1'b0);
    check("rand_timeout", timeout, 1'b0);

    // Stray response in IDLE.
    step('0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk) check("stray_no_strobe", cli_rsp_valid, '0);
    idle();
    @(negedge clk) check("stray_rsp_err", rsp_err, 1'b1);

    // Flush aggregation, including a redundant flush_req mid-flush.
    step('0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0);
    @(negedge clk) check("flush_busy_set", flush_busy, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    @(negedge clk) check("flush_mid_req", flush_complete, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    @(negedge clk) check("flush_after_c1", flush_complete, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0);
    @(negedge clk) check("flush_complete", flush_complete, 1'b1);
    idle();
    @(negedge clk) check("flush_busy_clear", flush_busy, 1'b0);
    // Done pulses while not busy must not count toward the next flush.
    step('0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
    step('0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0, 4'b0111, 1'b0);
    @(negedge clk) check("flush2_partial", flush_complete, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
    @(negedge clk) check("flush2_complete", flush_complete, 1'b1);
    idle();

    // Watchdog: flag exactly TO cycles after WAIT_RSP entry, late response still delivered.
    step(4'b0100, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      idle();
      if (k == TO - 1) @(negedge clk) check("timeout_before", timeout, 1'b0);
      if (k == TO)     @(negedge clk) check("timeout_at", timeout, 1'b1);
    end
    step('0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk) check("late_rsp", cli_rsp_valid, 4'b0100);
    idle();
    @(negedge clk);
    check("timeout_sticky", timeout, 1'b1);
    check("rsp_err_sticky", rsp_err, 1'b1);

    // Reset while waiting for a response, then a stray response.
    step(4'b0100, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    idle();
    step('0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle();
    @(negedge clk) check_reset_values("midreset");
    step('0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk) check("post_reset_stray", cli_rsp_valid, '0);
    idle();
    @(negedge clk) check("post_reset_rsp_err", rsp_err, 1'b1);

    idle();
    @(negedge clk);
    check("grants_left", grant_q.size(), 0);
    check("rsps_left", rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter_n.md
Name: l1_mem_arbiter_n

Overview:
N-client arbiter that shares one cache-line memory port among the L1 caches: L1D, L1I, a future L2 prefetcher and the page-table walker. It latches request pulses, grants clients round-robin and issues one outstanding transaction at a time. It handles the ack/response handshake and routes each response back to the granted client. It also aggregates per-cache flush completion into a single flush-busy indication for the core.

Parameters:
N_CLIENTS, 4, number of requesting caches (2..8)
ADDR_W, 64, memory address width
LINE_W, 128, cache-line data width in bits
TAG_W, 2, memory tag width
OP_W, 5, memory opcode width
TIMEOUT, 1024, cycles in WAIT_RSP before the timeout flag sets
CW, $clog2(N_CLIENTS), client index width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cli_req_valid  in  N_CLIENTS  one-cycle request pulse per client
cli_req_addr  in  N_CLIENTS*ADDR_W  per-client address; held stable until that client's rsp
cli_req_store_data  in  N_CLIENTS*LINE_W  per-client store line
cli_req_tag  in  N_CLIENTS*TAG_W  per-client tag
cli_req_opcode  in  N_CLIENTS*OP_W  per-client opcode
cli_rsp_valid  out  N_CLIENTS  one-hot response strobe
mem_req_valid  out  1  request to memory
mem_req_ack  in  1  memory accepted request
mem_req_addr  out  ADDR_W  muxed address of granted client
mem_req_store_data  out  LINE_W  muxed store data
mem_req_tag  out  TAG_W  muxed tag
mem_req_opcode  out  OP_W  muxed opcode
mem_req_client  out  CW  granted client index
mem_rsp_valid  in  1  memory response strobe; data and tag are broadcast to clients externally
flush_req  in  1  start flush aggregation
cli_flush_done  in  N_CLIENTS  per-client flush-complete pulses
flush_busy  out  1  aggregation in progress
flush_complete  out  1  one-cycle pulse when all clients are done
rsp_err  out  1  sticky: response received with no transaction outstanding
timeout  out  1  sticky: WAIT_RSP exceeded TIMEOUT

Behaviour:
- Pending: r_pend[i] sets on cli_req_valid[i] and clears in the cycle client i is granted. A pulse while already pending or granted is a protocol error; it is ignored.
- FSM states: IDLE, REQ, WAIT_RSP.
  - IDLE, with any bit set in (r_pend | cli_req_valid): select a winner, register r_gnt, go to REQ. mem_req_valid is high in the next cycle, so latency from pulse to mem_req_valid is 1 cycle.
  - REQ: mem_req_valid=1. On mem_req_ack, go to WAIT_RSP. If mem_req_ack and mem_rsp_valid arrive together, go straight to IDLE and strobe the response.
  - WAIT_RSP: mem_req_valid=0. On mem_rsp_valid, cli_rsp_valid[r_gnt]=1 (combinational, same cycle) and go to IDLE.
  - A new grant can be made in the cycle after the response.
- Round-robin:
  - Search order r_last+1 .. r_last+N_CLIENTS, modulo N_CLIENTS; the first requester wins.
  - r_last updates to the winner on grant. r_last resets to N_CLIENTS-1, so client 0 wins the first tie.
- mem_req_* are muxed from r_gnt and are valid whenever mem_req_valid=1. mem_req_client=r_gnt at all times.
- mem_rsp_valid in IDLE, or in REQ without ack: no cli_rsp_valid; rsp_err sets.
- Watchdog: a CW-independent counter of $clog2(TIMEOUT)+1 bits.
  - Clears on entry to WAIT_RSP and increments each WAIT_RSP cycle.
  - Sets timeout when it reaches TIMEOUT.
  - The FSM keeps waiting; there is no abort.
- Flush aggregation:
  - In FLUSH_IDLE, flush_req sets flush_busy and clears r_done_mask.
  - While busy, cli_flush_done[i] sets r_done_mask[i].
  - When (r_done_mask | cli_flush_done) is all ones: flush_complete pulses that cycle and flush_busy is 0 the next cycle.
  - flush_req while busy is ignored. Done pulses while not busy are ignored. Simultaneous done pulses are all counted.
- Arbitration continues during flush; write-backs need the port.
- Reset values: state IDLE, r_pend=0, r_gnt=0, r_last=N_CLIENTS-1, mem_req_valid=0, cli_rsp_valid=0, flush_busy=0, flush_complete=0, rsp_err=0, timeout=0, watchdog=0.
- Reset mid-transaction drops the transaction and all pending requests. A later stray response sets rsp_err.

Decomposition:
- Shared package (mem_arb_pkg): arb_state_t enum {IDLE, REQ, WAIT_RSP}; flush_state_t {FLUSH_IDLE, FLUSH_BUSY}.
- One sub-module: rr_pick (combinational round-robin priority picker). Inputs: req vector, last index. Outputs: any, winner index.

Test Plan:
- Single client 1 pulse at t0 → mem_req_valid=1, mem_req_client=1 at t1. Ack at t3 → valid=0. Rsp at t5 → cli_rsp_valid=4'b0010 at t5; IDLE at t6.
- Clients 0,2,3 pulse together after reset → grant order 0,2,3. Then client 0 re-pulses while 3 is in service and client 2 also pulses → next order 0,2 (pointer after 3 wraps to 0).
- Ack and rsp in the same cycle in REQ → response strobed that cycle, IDLE next cycle, rsp_err stays 0.
- Stray mem_rsp_valid in IDLE → no cli_rsp_valid; rsp_err=1 and remains 1 until reset.
- flush_req, then done pulses on clients 0 and 3 together, then 1, then 2 → flush_complete pulses on the client-2 cycle; flush_busy=0 the next cycle. A flush_req mid-flush has no effect.
- No rsp for TIMEOUT=16 cycles after ack → timeout=1 exactly 16 cycles after WAIT_RSP entry. A late rsp is still delivered. Reset in WAIT_RSP → all outputs return to reset values the next cycle.
